// File: rtl/pixel_writer.sv
// Framebuffer write stage: buffers rasteriser pixels in a FIFO and issues one Avalon-MM write per pixel.
// Optional build macro PIXEL_CLIP_EN: discard off-screen pixels and count them on pixels_clipped.
module pixel_writer #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pixel_data,
  input  logic        pixel_data_valid,
  output logic        pixel_fifo_full,
  input  logic [31:0] fb_base,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        overflow,
  output logic [31:0] pixels_written
`ifdef PIXEL_CLIP_EN
  ,
  output logic [31:0] pixels_clipped
`endif
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned FULL_TH = FIFO_DEPTH - FULL_MARGIN;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [31:0] colour;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  pix_t            r_mem [FIFO_DEPTH];
  pix_t            r_pix;
  pix_t            w_in_pix;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            w_push;
  logic            w_pop;
  logic            w_clip;
  logic            w_write_next;
  logic            w_done;
  logic [31:0]     w_offset;
  logic [31:0]     w_addr;
  logic            w_unused;

  assign w_in_pix = '{x: pixel_data[59:48], y: pixel_data[43:32], colour: pixel_data[31:0]};
  assign w_unused = ^{pixel_data[63:60], pixel_data[47:44], 32'(V_RES)};

  assign w_push = pixel_data_valid && (r_count < CW'(FIFO_DEPTH));
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  // Constant multiply by the row pitch; fits one cycle
  assign w_offset = (32'(r_pix.y) * 32'(H_RES) + 32'(r_pix.x)) << 2;
  assign w_addr   = fb_base + w_offset;

`ifdef PIXEL_CLIP_EN
  assign w_clip = (32'(r_pix.x) >= 32'(H_RES)) || (32'(r_pix.y) >= 32'(V_RES));
`else
  assign w_clip = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and write-request control
  always_comb begin
    w_state_next = r_state;
    w_write_next = avm_write;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_next = S_CALC;
      end
      S_CALC: begin
        if (w_clip) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WRITE;
          w_write_next = 1'b1;
        end
      end
      S_WRITE: begin
        if (avm_write && !avm_waitrequest) begin
          w_done       = 1'b1;
          w_write_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_write_next = 1'b0;
      end
    endcase
  end

  // FIFO storage carries no reset
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_pix;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_pix           <= '0;
      avm_address     <= '0;
      avm_writedata   <= '0;
      avm_write       <= 1'b0;
      pixels_written  <= '0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
      pixel_fifo_full <= 1'b0;
`ifdef PIXEL_CLIP_EN
      pixels_clipped  <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_pix    <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      if ((r_state == S_CALC) && !w_clip) begin
        avm_address   <= w_addr;
        avm_writedata <= r_pix.colour;
      end
      avm_write <= w_write_next;
      if (w_done) pixels_written <= pixels_written + 32'd1;
      if (pixel_data_valid && (r_count == CW'(FIFO_DEPTH))) overflow <= 1'b1;
      // Threshold taken from the count before this edge; margin covers that lag
      pixel_fifo_full <= (r_count >= CW'(FULL_TH));
      busy            <= (w_count_next != '0) || (w_state_next != S_IDLE);
`ifdef PIXEL_CLIP_EN
      if ((r_state == S_CALC) && w_clip) pixels_clipped <= pixels_clipped + 32'd1;
`endif
    end
  end

  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, stall hold, FIFO full/overflow, ordering, reset abort.
// Expectations for the off-screen case follow the PIXEL_CLIP_EN build macro.
module tb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pixel_data;
  logic        pixel_data_valid;
  logic        pixel_fifo_full;
  logic [31:0] fb_base;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        busy;
  logic        overflow;
  logic [31:0] pixels_written;
`ifdef PIXEL_CLIP_EN
  logic [31:0] pixels_clipped;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] wq [$];

  pixel_writer dut (
    .clock            (clock),
    .reset            (reset),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .pixel_fifo_full  (pixel_fifo_full),
    .fb_base          (fb_base),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .busy             (busy),
    .overflow         (overflow),
    .pixels_written   (pixels_written)
`ifdef PIXEL_CLIP_EN
    ,
    .pixels_clipped   (pixels_clipped)
`endif
  );

  always #5 clock = ~clock;

  // Record each write that the coming edge completes
  always @(negedge clock) begin
    if (!reset && avm_write && !avm_waitrequest) wq.push_back({avm_address, avm_writedata});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix(input int x, input int y, input logic [31:0] col);
    return {16'(x), 16'(y), col};
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int x, input int y);
    return base + 32'((y * 640 + x) * 4);
  endfunction

  task automatic push(input logic [63:0] d);
    pixel_data       = d;
    pixel_data_valid = 1'b1;
    tick();
    pixel_data_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int budget);
    for (int i = 0; i < budget && avm_write !== 1'b1; i++) tick();
    chk(tag, 64'(avm_write), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    pixel_data       = '0;
    pixel_data_valid = 1'b0;
    fb_base          = 32'h1000_0000;
    avm_waitrequest  = 1'b0;

    // 1: reset values, single pixel latency and address
    tick();
    tick();
    chk("rst_write", 64'(avm_write), 64'd0);
    chk("rst_be", 64'(avm_byteenable), 64'hF);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_data", 64'(avm_writedata), 64'd0);
    chk("rst_count", 64'(pixels_written), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_full", 64'(pixel_fifo_full), 64'd0);
    reset = 1'b0;
    tick();
    wq.delete();
    push(pix(3, 2, 32'hFF00FF00));
    chk("t1_n_write", 64'(avm_write), 64'd0);
    tick();
    chk("t1_n1_write", 64'(avm_write), 64'd0);
    chk("t1_n1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_n2_write", 64'(avm_write), 64'd1);
    chk("t1_addr", 64'(avm_address), 64'h1000_140C);
    chk("t1_data", 64'(avm_writedata), 64'hFF00FF00);
    tick();
    chk("t1_done_write", 64'(avm_write), 64'd0);
    chk("t1_done_count", 64'(pixels_written), 64'd1);
    chk("t1_done_busy", 64'(busy), 64'd0);
    chk("t1_nwr", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("t1_rec", wq[0], {32'h1000_140C, 32'hFF00FF00});

    // 2: stall holds the request stable, one completion
    wq.delete();
    avm_waitrequest = 1'b1;
    push(pix(10, 1, 32'h1234_5678));
    wait_write("t2_wait", 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_write", 64'(avm_write), 64'd1);
      chk("t2_hold_addr", 64'(avm_address), 64'h1000_0A28);
      chk("t2_hold_data", 64'(avm_writedata), 64'h1234_5678);
    end
    chk("t2_stall_count", 64'(pixels_written), 64'd1);
    avm_waitrequest = 1'b0;
    tick();
    chk("t2_rel_write", 64'(avm_write), 64'd0);
    tick();
    tick();
    chk("t2_count", 64'(pixels_written), 64'd2);
    chk("t2_nwr", 64'(wq.size()), 64'd1);

    // 3: fill while stalled: almost-full timing, overflow, ordered drain
    wq.delete();
    avm_waitrequest = 1'b1;
    push(pix(0, 0, 32'hC0DE_0000));
    wait_write("t3_wait", 10);
    pixel_data_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      pixel_data = pix(i, i, 32'hC0DE_0000 | 32'(i));
      tick();
      if (i == 14) chk("t3_full_at14", 64'(pixel_fifo_full), 64'd0);
      if (i == 15) chk("t3_full_at15", 64'(pixel_fifo_full), 64'd1);
      if (i == 16) chk("t3_ovf_at16", 64'(overflow), 64'd0);
    end
    pixel_data_valid = 1'b0;
    chk("t3_ovf", 64'(overflow), 64'd1);
    avm_waitrequest = 1'b0;
    wait_idle("t3_idle", 200);
    chk("t3_nwr", 64'(wq.size()), 64'd17);
    for (int i = 0; i < 17 && i < wq.size(); i++)
      chk($sformatf("t3_order%0d", i), wq[i],
          {ref_addr(32'h1000_0000, i, i), 32'hC0DE_0000 | 32'(i)});
    chk("t3_count", 64'(pixels_written), 64'd19);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);
    chk("t3_full_clr", 64'(pixel_fifo_full), 64'd0);

    // 4: off-screen coordinates
    do_reset();
    chk("t4_ovf_rst", 64'(overflow), 64'd0);
    chk("t4_cnt_rst", 64'(pixels_written), 64'd0);
    wq.delete();
    fb_base = 32'h2000_0000;
    push(pix(640, 0, 32'hAAAA_0001));
    push(pix(0, 479, 32'hAAAA_0002));
    wait_idle("t4_idle", 50);
`ifdef PIXEL_CLIP_EN
    chk("t4_nwr", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("t4_rec0", wq[0], {32'h2012_B600, 32'hAAAA_0002});
    chk("t4_clipped", 64'(pixels_clipped), 64'd1);
    chk("t4_count", 64'(pixels_written), 64'd1);
`else
    chk("t4_nwr", 64'(wq.size()), 64'd2);
    if (wq.size() > 0) chk("t4_rec0", wq[0], {32'h2000_0A00, 32'hAAAA_0001});
    if (wq.size() > 1) chk("t4_rec1", wq[1], {32'h2012_B600, 32'hAAAA_0002});
    chk("t4_count", 64'(pixels_written), 64'd2);
`endif

    // 5: reset during a stalled write with pixels queued
    avm_waitrequest = 1'b1;
    pixel_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pixel_data = pix(i + 20, 5, 32'h5555_0000 | 32'(i));
      tick();
    end
    pixel_data_valid = 1'b0;
    wait_write("t5_wait", 10);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    wq.delete();
    reset = 1'b1;
    tick();
    chk("t5_rst_write", 64'(avm_write), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_nwr", 64'(wq.size()), 64'd0);
    chk("t5_count", 64'(pixels_written), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);

    // 6: push every cycle while popping; nothing lost
    fb_base = 32'h0;
    wq.delete();
    pixel_data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pixel_data = pix(i, 2 * i, 32'h0000_0600 | 32'(i));
      tick();
    end
    pixel_data_valid = 1'b0;
    wait_idle("t6_idle", 100);
    chk("t6_nwr", 64'(wq.size()), 64'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      chk($sformatf("t6_order%0d", i), wq[i], {ref_addr(32'h0, i, 2 * i), 32'h0000_0600 | 32'(i)});
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_count", 64'(pixels_written), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
